// File: rtl/jtag_host_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtag_host_controller: Wishbone-slave JTAG host shifting 1..32 TMS/TDI bits |
// | Optional: define JTAG_HOST_IRQ_EN to add the irq_o completion interrupt.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module jtag_host_controller #(
  parameter logic [7:0] DEFAULT_CLOCK_DIV = 8'd3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_data_i,
  input  logic [23:0] wb_adr_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic        wb_error_o,
  output logic [31:0] wb_data_o,
  output logic        jtag_tck,
  output logic        jtag_tms,
  output logic        jtag_tdi,
  input  logic        jtag_tdo
`ifdef JTAG_HOST_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT       r_state, w_nextState;
  logic [7:0]  r_clkDiv, r_shiftDiv, r_phase;
  logic [4:0]  r_len, r_bit;
  logic [31:0] r_tms, r_tdi, r_tdo;
  logic        r_done;
  logic [31:0] w_rdata;
  logic        w_irqEnBit;

  wire       w_req       = wb_cyc_i & wb_stb_i;
  wire [2:0] w_reg       = wb_adr_i[4:2];
  wire       w_busy      = (r_state != IDLE);
  wire       w_err       = (w_reg > 3'd4) || (wb_we_i && ((w_reg == 3'd4) || w_busy));
  wire       w_wr        = w_req & wb_we_i & ~w_err;
  wire       w_ctrlWr    = w_wr && (w_reg == 3'd0);
  wire       w_start     = w_ctrlWr & wb_sel_i[1] & wb_data_i[8];
  wire       w_phaseLast = (r_phase == r_shiftDiv);
  wire       w_lastBit   = (r_bit == r_len);
  wire       w_shiftEnd  = (r_state == HIGH) && w_phaseLast && w_lastBit;
  wire [4:0] w_nextBit   = r_bit + 5'd1;
  wire       w_unused    = &{1'b0, wb_adr_i[23:5], wb_adr_i[1:0]};

  assign wb_stall_o = 1'b0;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldV, input logic [31:0] newV,
                                             input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = sel[b] ? newV[8*b +: 8] : oldV[8*b +: 8];
    return res;
  endfunction

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start) w_nextState = LOW;
      LOW:     if (w_phaseLast) w_nextState = HIGH;
      HIGH:    if (w_phaseLast) w_nextState = w_lastBit ? DONE : LOW;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      3'd0: begin
        w_rdata[0]    = w_busy;
        w_rdata[1]    = r_done;
        w_rdata[12:8] = r_len;
        w_rdata[16]   = w_irqEnBit;
      end
      3'd1:    w_rdata[7:0] = r_clkDiv;
      3'd2:    w_rdata = r_tms;
      3'd3:    w_rdata = r_tdi;
      3'd4:    w_rdata = r_tdo;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state    <= IDLE;
      r_clkDiv   <= DEFAULT_CLOCK_DIV;
      r_shiftDiv <= DEFAULT_CLOCK_DIV;
      r_phase    <= '0;
      r_len      <= '0;
      r_bit      <= '0;
      r_tms      <= '0;
      r_tdi      <= '0;
      r_tdo      <= '0;
      r_done     <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_error_o <= 1'b0;
      wb_data_o  <= '0;
      jtag_tck   <= 1'b0;
      jtag_tms   <= 1'b1;
      jtag_tdi   <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      wb_ack_o   <= w_req & ~w_err;
      wb_error_o <= w_req & w_err;
      if (w_req && !wb_we_i && !w_err) wb_data_o <= w_rdata;

      // Writes only land while idle, so they never race the shift engine below.
      if (w_wr) begin
        case (w_reg)
          3'd0:    if (wb_sel_i[0]) r_len <= wb_data_i[4:0];
          3'd1:    if (wb_sel_i[0]) r_clkDiv <= wb_data_i[7:0];
          3'd2:    r_tms <= mergeBytes(r_tms, wb_data_i, wb_sel_i);
          3'd3:    r_tdi <= mergeBytes(r_tdi, wb_data_i, wb_sel_i);
          default: ;
        endcase
      end

      if (w_start) begin
        r_shiftDiv <= r_clkDiv;
        r_bit      <= '0;
        r_tdo      <= '0;
        r_done     <= 1'b0;
        jtag_tms   <= r_tms[0];
        jtag_tdi   <= r_tdi[0];
      end

      if (w_nextState != r_state) r_phase <= '0;
      else if (w_busy)            r_phase <= r_phase + 8'd1;

      if ((r_state == HIGH) && w_phaseLast) begin
        r_tdo[r_bit] <= jtag_tdo;
        if (!w_lastBit) begin
          r_bit    <= w_nextBit;
          jtag_tms <= r_tms[w_nextBit];
          jtag_tdi <= r_tdi[w_nextBit];
        end
      end

      if (w_shiftEnd) r_done <= 1'b1;
      jtag_tck <= (w_nextState == HIGH);
    end
  end

`ifdef JTAG_HOST_IRQ_EN
  logic r_irqEn;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_irqEn <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      if (w_ctrlWr && wb_sel_i[1]) r_irqEn <= wb_data_i[9];
      if (w_shiftEnd && r_irqEn)   irq_o <= 1'b1;
      else if (w_start || (w_ctrlWr && wb_sel_i[0] && wb_data_i[1])) irq_o <= 1'b0;
    end
  end

  assign w_irqEnBit = r_irqEn;
`else
  assign w_irqEnBit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtag_host_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jtag_host_controller: directed self-checking bench for the JTAG host    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_jtag_host_controller;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_data_i = '0;
  logic [23:0] wb_adr_i = '0;
  logic        wb_ack_o, wb_stall_o, wb_error_o;
  logic [31:0] wb_data_o;
  logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
`ifdef JTAG_HOST_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  logic        loopMode = 1'b0;
  logic [31:0] tdoPattern = '0;
  logic [4:0]  bitIdx = '0;
  int          rises = 0, highCycles = 0, tmsAtRise = 0;
  logic        prevTck = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  assign jtag_tdo = loopMode ? jtag_tdi : tdoPattern[bitIdx];

  // Target-style model: next TDO bit presented after each falling TCK.
  always @(negedge jtag_tck) bitIdx = bitIdx + 5'd1;

  always @(negedge wb_clk_i) begin
    if (jtag_tck && !prevTck) begin
      rises++;
      if (jtag_tms) tmsAtRise++;
    end
    if (jtag_tck) highCycles++;
    prevTck = jtag_tck;
  end

  jtag_host_controller #(.DEFAULT_CLOCK_DIV(8'd3)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_data_i(wb_data_i), .wb_adr_i(wb_adr_i),
    .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o), .wb_error_o(wb_error_o),
    .wb_data_o(wb_data_o), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_tdo(jtag_tdo)
`ifdef JTAG_HOST_IRQ_EN
    , .irq_o(irq)
`endif
  );

  task automatic busAccess(input logic weV, input logic [23:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic ackV, output logic errV,
                           output logic [31:0] rd);
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = weV;
    wb_adr_i = a; wb_data_i = d; wb_sel_i = s;
    @(posedge wb_clk_i);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    ackV = wb_ack_o; errV = wb_error_o; rd = wb_data_o;
  endtask

  task automatic clearMonitors();
    rises = 0; highCycles = 0; tmsAtRise = 0; bitIdx = '0;
  endtask

  task automatic waitIdle(output int busyPolls);
    logic a, e;
    logic [31:0] rd;
    int n;
    busyPolls = 0; n = 0;
    do begin
      busAccess(1'b0, 24'h0, 32'h0, 4'h0, a, e, rd);
      if (rd[0]) busyPolls++;
      n++;
    end while (rd[0] && n < 3000);
    checks++;
    if (rd[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0d after %0d polls, required 0", rd[0], n);
    end
  endtask

  task automatic test_reset();
    logic a, e;
    logic [31:0] rd;
    busAccess(1'b1, 24'h4, 32'h55, 4'hF, a, e, rd);
    busAccess(1'b1, 24'h8, 32'hFFFF_0000, 4'hF, a, e, rd);
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 24'h0;
    #2 wb_rst_i = 1'b0;
    #1;
    checks++;
    if ({jtag_tck, jtag_tms, jtag_tdi, wb_ack_o, wb_error_o} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_pins: tck/tms/tdi/ack/err=%b, required 01000",
               {jtag_tck, jtag_tms, jtag_tdi, wb_ack_o, wb_error_o});
    end
    @(posedge wb_clk_i); #1;
    checks++;
    if ({wb_ack_o, wb_error_o, wb_data_o} !== 34'h0) begin
      errors++;
      $display("FAIL reset_bus: ack=%b err=%b data=%h, required 0 0 0", wb_ack_o, wb_error_o, wb_data_o);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge wb_clk_i) wb_rst_i = 1'b1;
    busAccess(1'b0, 24'h4, 32'h0, 4'h0, a, e, rd);
    checks++;
    if ({a, e, rd} !== {2'b10, 32'h3}) begin
      errors++;
      $display("FAIL reset_clkdiv: ack=%b err=%b data=%h, required 1 0 00000003", a, e, rd);
    end
    busAccess(1'b0, 24'h8, 32'h0, 4'h0, a, e, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_tms: got %h, required 00000000", rd);
    end
    // IRQEN readback without starting a shift
    busAccess(1'b1, 24'h0, 32'h200, 4'h3, a, e, rd);
    busAccess(1'b0, 24'h0, 32'h0, 4'h0, a, e, rd);
    checks++;
`ifdef JTAG_HOST_IRQ_EN
    if (rd !== 32'h0001_0000) begin
      errors++;
      $display("FAIL irqen_readback: got %h, required 00010000", rd);
    end
`else
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL irqen_readback: got %h, required 00000000", rd);
    end
`endif
  endtask

  task automatic test_byte_select();
    logic a, e;
    logic [31:0] rd;
    busAccess(1'b1, 24'h8, 32'h0, 4'hF, a, e, rd);
    busAccess(1'b1, 24'h8, 32'hAABB_CCDD, 4'h5, a, e, rd);
    busAccess(1'b0, 24'h8, 32'h0, 4'h0, a, e, rd);
    checks++;
    if (rd !== 32'h00BB_00DD) begin
      errors++;
      $display("FAIL byte_select_tms: got %h, required 00BB00DD", rd);
    end
    busAccess(1'b1, 24'h10, 32'h1234, 4'hF, a, e, rd);
    checks++;
    if ({a, e} !== 2'b01) begin
      errors++;
      $display("FAIL write_tdo: ack=%b err=%b, required 0 1", a, e);
    end
  endtask

  task automatic test_short_shift();
    logic a, e;
    logic [31:0] rd;
    int busy;
    busAccess(1'b1, 24'h4, 32'h0, 4'hF, a, e, rd);
    busAccess(1'b1, 24'h8, 32'h1F, 4'hF, a, e, rd);
    busAccess(1'b1, 24'hC, 32'h0, 4'hF, a, e, rd);
    clearMonitors();
    busAccess(1'b1, 24'h0, 32'h104, 4'hF, a, e, rd);
    waitIdle(busy);
    checks++;
    if (busy !== 11) begin
      errors++;
      $display("FAIL short_busy: got %0d cycles, required 11", busy);
    end
    checks++;
    if ({rises, highCycles, tmsAtRise} !== {32'd5, 32'd5, 32'd5}) begin
      errors++;
      $display("FAIL short_pulses: rises=%0d high=%0d tms1=%0d, required 5 5 5", rises, highCycles, tmsAtRise);
    end
    busAccess(1'b0, 24'h0, 32'h0, 4'h0, a, e, rd);
    checks++;
    if (rd !== 32'h0000_0402) begin
      errors++;
      $display("FAIL short_status: got %h, required 00000402", rd);
    end
  endtask

  task automatic test_loopback();
    logic a, e;
    logic [31:0] rd;
    int busy;
    busAccess(1'b1, 24'h4, 32'h1, 4'hF, a, e, rd);
    busAccess(1'b1, 24'hC, 32'hA5, 4'hF, a, e, rd);
    loopMode = 1'b1;
    clearMonitors();
    busAccess(1'b1, 24'h0, 32'h107, 4'hF, a, e, rd);
    waitIdle(busy);
    loopMode = 1'b0;
    busAccess(1'b0, 24'h10, 32'h0, 4'h0, a, e, rd);
    checks++;
    if (rd !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL loop_tdo: got %h, required 000000A5", rd);
    end
    checks++;
    if ({busy, rises, highCycles} !== {32'd33, 32'd8, 32'd16}) begin
      errors++;
      $display("FAIL loop_timing: busy=%0d rises=%0d high=%0d, required 33 8 16", busy, rises, highCycles);
    end
  endtask

  task automatic test_busy_errors();
    logic a, e;
    logic [31:0] rd;
    int busy;
    busAccess(1'b1, 24'h4, 32'h5, 4'hF, a, e, rd);
    busAccess(1'b1, 24'hC, 32'h1234_5678, 4'hF, a, e, rd);
    busAccess(1'b1, 24'h0, 32'h11F, 4'hF, a, e, rd);
    busAccess(1'b1, 24'hC, 32'hFFFF_FFFF, 4'hF, a, e, rd);
    checks++;
    if ({a, e} !== 2'b01) begin
      errors++;
      $display("FAIL busy_write: ack=%b err=%b, required 0 1", a, e);
    end
    busAccess(1'b0, 24'h0, 32'h0, 4'h0, a, e, rd);
    checks++;
    if ({a, e, rd[0]} !== 3'b101) begin
      errors++;
      $display("FAIL busy_status: ack=%b err=%b busy=%b, required 1 0 1", a, e, rd[0]);
    end
    busAccess(1'b0, 24'h14, 32'h0, 4'h0, a, e, rd);
    checks++;
    if ({a, e} !== 2'b01) begin
      errors++;
      $display("FAIL bad_address: ack=%b err=%b, required 0 1", a, e);
    end
    waitIdle(busy);
    busAccess(1'b0, 24'hC, 32'h0, 4'h0, a, e, rd);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL tdi_unchanged: got %h, required 12345678", rd);
    end
  endtask

  task automatic test_full_width();
    logic a, e;
    logic [31:0] rd;
    int busy;
    busAccess(1'b1, 24'h4, 32'h2, 4'hF, a, e, rd);
    tdoPattern = 32'hDEAD_BEEF;
    clearMonitors();
    busAccess(1'b1, 24'h0, 32'h11F, 4'hF, a, e, rd);
    waitIdle(busy);
    busAccess(1'b0, 24'h10, 32'h0, 4'h0, a, e, rd);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL full_tdo: got %h, required DEADBEEF", rd);
    end
    checks++;
    if ({busy, rises, highCycles} !== {32'd193, 32'd32, 32'd96}) begin
      errors++;
      $display("FAIL full_timing: busy=%0d rises=%0d high=%0d, required 193 32 96", busy, rises, highCycles);
    end
    // Reset in the middle of a shift that drives tms=0, tdi=1
    busAccess(1'b1, 24'h8, 32'h0, 4'hF, a, e, rd);
    busAccess(1'b1, 24'hC, 32'hFFFF_FFFF, 4'hF, a, e, rd);
    busAccess(1'b1, 24'h0, 32'h11F, 4'hF, a, e, rd);
    repeat (20) @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b0;
    #1;
    checks++;
    if ({jtag_tck, jtag_tms, jtag_tdi} !== 3'b010) begin
      errors++;
      $display("FAIL midshift_reset: tck/tms/tdi=%b, required 010", {jtag_tck, jtag_tms, jtag_tdi});
    end
    @(negedge wb_clk_i) wb_rst_i = 1'b1;
    busAccess(1'b0, 24'h0, 32'h0, 4'h0, a, e, rd);
    checks++;
    if (rd[1:0] !== 2'b00) begin
      errors++;
      $display("FAIL midshift_status: done/busy=%b, required 00", rd[1:0]);
    end
  endtask

`ifdef JTAG_HOST_IRQ_EN
  task automatic test_irq();
    logic a, e;
    logic [31:0] rd;
    int busy;
    busAccess(1'b1, 24'h4, 32'h0, 4'hF, a, e, rd);
    busAccess(1'b1, 24'h0, 32'h300, 4'hF, a, e, rd);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: got %b, required 0", irq);
    end
    waitIdle(busy);
    checks++;
    if ({irq, busy} !== {1'b1, 32'd3}) begin
      errors++;
      $display("FAIL irq_set: irq=%b busy=%0d, required 1 3", irq, busy);
    end
    busAccess(1'b1, 24'h0, 32'h2, 4'h1, a, e, rd);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_w1c: got %b, required 0", irq);
    end
    busAccess(1'b1, 24'h0, 32'h100, 4'hF, a, e, rd);
    waitIdle(busy);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_disabled: got %b, required 0", irq);
    end
  endtask
`endif

  initial begin
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i) wb_rst_i = 1'b1;
    test_reset();
    test_byte_select();
    test_short_shift();
    test_loopback();
    test_busy_errors();
    test_full_width();
`ifdef JTAG_HOST_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
